// File: rtl/beat_sequencer.sv
// beat_sequencer: one-hot W1/W2/W3 machine-cycle beat generator and run
// controller with beat and instruction counters, clocked on falling t3.
module beat_sequencer #(
    parameter int BEAT_CNT_W  = 8,
    parameter int INSTR_CNT_W = 16
) (
    input  logic                   t3,
    input  logic                   clr,
    input  logic                   qd,
    input  logic                   step_mode,
    input  logic                   short,
    input  logic                   long,
    input  logic                   stop,
    output logic                   w1,
    output logic                   w2,
    output logic                   w3,
    output logic                   running,
    output logic                   instr_end,
    output logic [BEAT_CNT_W-1:0]  beat_cnt,
    output logic [INSTR_CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_t;

    localparam logic [BEAT_CNT_W-1:0]  BEAT_ONE  = 1;
    localparam logic [INSTR_CNT_W-1:0] INSTR_ONE = 1;

    state_t state;
    state_t state_n;
    logic   stop_pend;
    logic   stop_pend_n;
    logic   qd_d;
    logic   start;
    logic   ends;
    logic   in_beat;

    assign start   = qd & ~qd_d;
    assign in_beat = (state != IDLE);

    always_comb begin
        state_n     = state;
        ends        = 1'b0;
        stop_pend_n = stop_pend;
        unique case (state)
            IDLE: if (start) state_n = B1;
            // short wins over long; long only matters at the end of B2
            B1:   if (short) ends = 1'b1;
                  else       state_n = B2;
            B2:   if (long)  state_n = B3;
                  else       ends = 1'b1;
            B3:   ends = 1'b1;
        endcase
        if (ends) begin
            state_n = (stop_pend | stop | step_mode) ? IDLE : B1;
        end
        if (ends) begin
            stop_pend_n = 1'b0;
        end else if (in_beat && stop) begin
            stop_pend_n = 1'b1;
        end
    end

    always_ff @(negedge t3 or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            qd_d      <= 1'b0;
            instr_end <= 1'b0;
            beat_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state     <= state_n;
            stop_pend <= stop_pend_n;
            qd_d      <= qd;
            instr_end <= ends;
            if (in_beat) begin
                beat_cnt <= beat_cnt + BEAT_ONE;
            end
            if (ends && (instr_cnt != '1)) begin
                instr_cnt <= instr_cnt + INSTR_ONE;
            end
        end
    end

    assign w1      = (state == B1);
    assign w2      = (state == B2);
    assign w3      = (state == B3);
    assign running = in_beat;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed self-checking bench for beat_sequencer: beat sequences, stop,
// single-step, async reset, beat wrap and instruction counter saturation.
module tb_beat_sequencer;

    logic        t3 = 1'b1;
    logic        clr;
    logic        qd;
    logic        step_mode;
    logic        short;
    logic        long;
    logic        stop;
    logic        w1;
    logic        w2;
    logic        w3;
    logic        running;
    logic        instr_end;
    logic [7:0]  beat_cnt;
    logic [15:0] instr_cnt;

    int errors = 0;
    int checks = 0;

    beat_sequencer dut (
        .t3        (t3),
        .clr       (clr),
        .qd        (qd),
        .step_mode (step_mode),
        .short     (short),
        .long      (long),
        .stop      (stop),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .running   (running),
        .instr_end (instr_end),
        .beat_cnt  (beat_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 t3 = ~t3;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge t3);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; qd = 1'b0; step_mode = 1'b0;
        short = 1'b0; long = 1'b0; stop = 1'b0;
        #3;
        chk("rst_w", {29'd0, w1, w2, w3}, 32'd0);
        chk("rst_run", {31'd0, running}, 32'd0);
        chk("rst_end", {31'd0, instr_end}, 32'd0);
        chk("rst_beat", {24'd0, beat_cnt}, 32'd0);
        chk("rst_instr", {16'd0, instr_cnt}, 32'd0);
        #9;
        clr = 1'b1;
        step();

        // continuous w1,w2 sequence
        qd = 1'b1;
        step();
        chk("t1_w1", {29'd0, w1, w2, w3}, 32'b100);
        chk("t1_run", {31'd0, running}, 32'd1);
        chk("t1_beat0", {24'd0, beat_cnt}, 32'd0);
        step();
        chk("t1_w2", {29'd0, w1, w2, w3}, 32'b010);
        chk("t1_beat1", {24'd0, beat_cnt}, 32'd1);
        step();
        chk("t1_w1b", {29'd0, w1, w2, w3}, 32'b100);
        chk("t1_iend", {31'd0, instr_end}, 32'd1);
        chk("t1_icnt1", {16'd0, instr_cnt}, 32'd1);
        step();
        chk("t1_w2b", {29'd0, w1, w2, w3}, 32'b010);
        chk("t1_iend0", {31'd0, instr_end}, 32'd0);
        step();
        chk("t1_beat4", {24'd0, beat_cnt}, 32'd4);
        chk("t1_icnt2", {16'd0, instr_cnt}, 32'd2);

        // stop in B1 without short: B2 still runs, then halt
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_w2", {29'd0, w1, w2, w3}, 32'b010);
        step();
        chk("t4_idle", {31'd0, running}, 32'd0);
        chk("t4_iend", {31'd0, instr_end}, 32'd1);
        chk("t4_icnt", {16'd0, instr_cnt}, 32'd3);
        chk("t4_beat", {24'd0, beat_cnt}, 32'd6);
        step();
        chk("t4_hold", {31'd0, running}, 32'd0);

        // release and press qd: resume at w1, then long + stop in B3
        qd = 1'b0;
        step();
        qd = 1'b1;
        step();
        chk("t2_w1", {29'd0, w1, w2, w3}, 32'b100);
        step();
        long = 1'b1;
        step();
        long = 1'b0;
        chk("t2_w3", {29'd0, w1, w2, w3}, 32'b001);
        chk("t2_beat", {24'd0, beat_cnt}, 32'd8);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_idle", {29'd0, w1, w2, w3}, 32'b000);
        chk("t2_iend", {31'd0, instr_end}, 32'd1);
        chk("t2_icnt", {16'd0, instr_cnt}, 32'd4);
        step();
        chk("t2_iend0", {31'd0, instr_end}, 32'd0);
        step();
        chk("t2_nostart", {31'd0, running}, 32'd0);

        // short+long+stop in B1: only w1
        qd = 1'b0;
        do_reset();
        short = 1'b1; long = 1'b1; stop = 1'b1; qd = 1'b1;
        step();
        chk("t3_w1", {29'd0, w1, w2, w3}, 32'b100);
        step();
        short = 1'b0; long = 1'b0; stop = 1'b0; qd = 1'b0;
        chk("t3_w2lo", {31'd0, w2}, 32'd0);
        chk("t3_run", {31'd0, running}, 32'd0);
        chk("t3_beat", {24'd0, beat_cnt}, 32'd1);
        chk("t3_icnt", {16'd0, instr_cnt}, 32'd1);

        // stop_pend cleared: next instruction chains straight to B1
        step();
        qd = 1'b1;
        step();
        step();
        step();
        chk("t4_chain", {29'd0, w1, w2, w3}, 32'b100);
        chk("t4_ciend", {31'd0, instr_end}, 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("t4_halt2", {31'd0, running}, 32'd0);

        // single-step: three pulses, three instructions
        qd = 1'b0;
        do_reset();
        step_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            qd = 1'b0;
            step();
            qd = 1'b1;
            step();
            step();
            step();
            chk("t5_gap", {31'd0, running}, 32'd0);
        end
        chk("t5_icnt", {16'd0, instr_cnt}, 32'd3);
        chk("t5_beat", {24'd0, beat_cnt}, 32'd6);
        step_mode = 1'b0;

        // async reset mid-B2
        qd = 1'b0;
        step();
        qd = 1'b1;
        step();
        step();
        chk("t6_w2", {29'd0, w1, w2, w3}, 32'b010);
        #2;
        clr = 1'b0;
        #1;
        chk("t6_w2drop", {29'd0, w1, w2, w3}, 32'b000);
        chk("t6_run", {31'd0, running}, 32'd0);
        chk("t6_beat", {24'd0, beat_cnt}, 32'd0);
        chk("t6_icnt", {16'd0, instr_cnt}, 32'd0);
        clr = 1'b1;

        // long run of one-beat instructions: wrap and saturate
        short = 1'b1;
        step();
        chk("t6_start", {29'd0, w1, w2, w3}, 32'b100);
        repeat (255) step();
        chk("t6_beatff", {24'd0, beat_cnt}, 32'hff);
        chk("t6_icnt255", {16'd0, instr_cnt}, 32'd255);
        step();
        chk("t6_wrap", {24'd0, beat_cnt}, 32'h00);
        chk("t6_icnt256", {16'd0, instr_cnt}, 32'd256);
        repeat (65535 - 256) step();
        chk("t6_icntmax", {16'd0, instr_cnt}, 32'hffff);
        chk("t6_beatmax", {24'd0, beat_cnt}, 32'hff);
        step();
        chk("t6_sat", {16'd0, instr_cnt}, 32'hffff);
        chk("t6_wrap2", {24'd0, beat_cnt}, 32'h00);
        short = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
